my_and: RTL and testbench
=========================

# my_and

Two-input logical AND gate with a purely combinational output. A registered copy of the output, an input-combination coverage tracker and a saturating count of cycles where the output is high sit alongside it. The block serves as the basic gate cell in the lab gate library. Its observation outputs let system benches confirm that all four truth-table rows were exercised.

## Interface
- `CNT_W`, 8: width of the high-cycle counter `hi_count`; legal range 1–32.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `input1`  in  1  first AND operand.
- `input2`  in  1  second AND operand.
- `op`  out  1  combinational `input1 & input2`.
- `op_q`  out  1  `op` registered once.
- `cov`  out  4  sticky truth-table coverage; bit index = `{input1,input2}`.
- `all_seen`  out  1  high when `cov == 4'b1111`.
- `hi_count`  out  CNT_W  saturating count of rising edges sampled with `op == 1`.

Reset is synchronous and active-high, on one clock `clk`, with reset port `rst`.

## Operation
- Output `op`:
  - `op = input1 & input2` at all times.
  - It has no dependence on `clk` or `rst`, including during reset.
  - Truth table: 00→0, 10→0, 01→0, 11→1.
- Registered copy `op_q`:
  - At each non-reset rising edge, `op_q <= input1 & input2`.
- Coverage `cov`:
  - At each non-reset edge, `cov[{input1,input2}] <= 1`.
  - Bits never clear except on reset.
  - Index mapping: `{0,0}`→bit0, `{0,1}`→bit1, `{1,0}`→bit2, `{1,1}`→bit3.
- `all_seen`:
  - Combinational AND-reduction of the registered `cov`.
- Counter `hi_count`:
  - At each non-reset edge with `op == 1`, increment by 1.
  - Saturates at 2^CNT_W−1 and holds there; never wraps.
- Reset (`rst == 1` at a rising edge) forces:
  - `op_q = 0`
  - `cov = 4'b0000`
  - `all_seen = 0`
  - `hi_count = 0`
- Reset overrides any simultaneous sample or increment.
- X/Z on either input is not a supported operating condition.

## Timing
- `op`: zero-cycle latency, combinational path only.
- `op_q`, `cov`, `hi_count`: one-cycle latency. The values reflect inputs sampled at the preceding rising edge.
- `all_seen`: follows `cov` in the same cycle, with no extra register.
- Input changes between edges affect `op` immediately. They do not affect the other outputs until the next edge.
- Reset asserted mid-operation:
  - Registered outputs clear at that edge.
  - The first edge after `rst` deasserts samples normally.
- No handshakes and no state machine.

## Structure
- Shared package `my_and_pkg`:
  - `CNT_W_DEFAULT = 8`.
  - typedef `combo_t` (2-bit `{input1,input2}` index).
  - constant `COV_ALL = 4'b1111`.
- Sub-module `my_and_cov` implements the sticky coverage vector and `all_seen`.
- The top level holds the gate, the `op_q` register and the saturating counter.

## Test plan
- **Combinational truth table.**
  - Stimulus: hold `rst=1`; apply 00, 10, 01, 11 with 5-time-unit spacing.
  - Required: `op` = 0, 0, 0, 1 within the same time step, unaffected by reset.
- **Registered copy.**
  - Stimulus: deassert reset; drive 11 then 01 on consecutive edges.
  - Required: `op_q` reads 1 after the first edge and 0 after the second.
- **Coverage.**
  - Stimulus: drive 00, 10, 01, 11 on four edges after reset.
  - Required: `cov` progresses 0001 → 0101 → 0111 → 1111; `all_seen` = 1 only after the fourth edge.
- **Saturation.**
  - Stimulus: `CNT_W=2`; hold 11 for 6 edges.
  - Required: `hi_count` reads 1, 2, 3, 3, 3, 3.
- **Reset mid-run.**
  - Stimulus: after `cov=1111` and `hi_count=5`, assert `rst` for one edge while inputs are 11.
  - Required: `op_q=0`, `cov=0000`, `all_seen=0`, `hi_count=0`; `op` stays 1.
  - Next edge with 11: `op_q=1`, `cov=1000`, `hi_count=1`.

Source files
------------

// File: rtl/my_and_pkg.sv
// Shared definitions for the my_and gate cell and its observation logic.
package my_and_pkg;

    // Default width of the high-cycle counter.
    localparam int CNT_W_DEFAULT = 8;

    // Truth-table row index, packed as {input1, input2}.
    typedef logic [1:0] combo_t;

    // Coverage value once all four truth-table rows have been sampled.
    localparam logic [3:0] COV_ALL = 4'b1111;

    // Build the row index from the two operands.
    function automatic combo_t make_combo(input logic a, input logic b);
        return {a, b};
    endfunction

endpackage : my_and_pkg

// File: rtl/my_and_cov.sv
// Sticky truth-table coverage tracker: one bit per {input1,input2} row,
// set when that row is sampled at a clock edge and cleared only by reset.
module my_and_cov
    import my_and_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  combo_t     combo,
    output logic [3:0] cov,
    output logic       all_seen
);

    logic [3:0] cov_d;
    logic [3:0] cov_q;

    // Next coverage vector: reset clears it, otherwise the sampled row is marked.
    always_comb begin
        cov_d = cov_q;
        if (rst) begin
            cov_d = 4'b0000;
        end else begin
            cov_d[combo] = 1'b1;
        end
    end

    // Coverage register.
    always_ff @(posedge clk) begin
        cov_q <= cov_d;
    end

    assign cov      = cov_q;
    // Follows the registered vector directly; no extra pipeline stage.
    assign all_seen = (cov_q == COV_ALL);

endmodule : my_and_cov

// File: rtl/my_and.sv
// Two-input AND gate cell with a registered copy of the output, sticky
// truth-table coverage and a saturating count of edges sampled with op high.
module my_and
    import my_and_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             input1,
    input  logic             input2,
    output logic             op,
    output logic             op_q,
    output logic [3:0]       cov,
    output logic             all_seen,
    output logic [CNT_W-1:0] hi_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             op_d;
    logic             op_r_q;
    logic [CNT_W-1:0] hi_count_d;
    logic [CNT_W-1:0] hi_count_q;

    // The gate itself: purely combinational, independent of clk and rst.
    assign op = input1 & input2;

    // Next values for the registered copy and the saturating counter.
    always_comb begin
        op_d       = 1'b0;
        hi_count_d = hi_count_q;
        if (rst) begin
            op_d       = 1'b0;
            hi_count_d = '0;
        end else begin
            op_d = op;
            if (op && (hi_count_q != CNT_MAX)) begin
                hi_count_d = hi_count_q + CNT_ONE;
            end else begin
                hi_count_d = hi_count_q;
            end
        end
    end

    // Registered copy of op and the high-cycle counter.
    always_ff @(posedge clk) begin
        op_r_q     <= op_d;
        hi_count_q <= hi_count_d;
    end

    assign op_q     = op_r_q;
    assign hi_count = hi_count_q;

    my_and_cov u_cov (
        .clk      (clk),
        .rst      (rst),
        .combo    (make_combo(input1, input2)),
        .cov      (cov),
        .all_seen (all_seen)
    );

endmodule : my_and

// File: tb/tb_my_and.sv
// Self-checking bench for my_and: directed scenarios followed by random
// stimulus, compared against a behavioural model of the gate's rules.
module tb_my_and;

    logic       clk;
    logic       rst;
    logic       input1;
    logic       input2;

    logic       op8, op_q8, all_seen8;
    logic [3:0] cov8;
    logic [7:0] hi_count8;
    logic       op2, op_q2, all_seen2;
    logic [3:0] cov2;
    logic [1:0] hi_count2;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    bit m_opq;
    bit m_seen [4];
    int m_cnt8;
    int m_cnt2;

    my_and #(.CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .input1(input1), .input2(input2),
        .op(op8), .op_q(op_q8), .cov(cov8), .all_seen(all_seen8),
        .hi_count(hi_count8)
    );

    my_and #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .input1(input1), .input2(input2),
        .op(op2), .op_q(op_q2), .cov(cov2), .all_seen(all_seen2),
        .hi_count(hi_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_add(input int cnt, input int inc, input int width);
        int lim;
        lim = (1 << width) - 1;
        return (cnt + inc > lim) ? lim : cnt + inc;
    endfunction

    task automatic check_regs(input string tag);
        logic [3:0] exp_cov;
        bit all;
        all = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_cov[i] = m_seen[i];
            all = all & m_seen[i];
        end
        check({tag, ".op_q8"},     32'(op_q8),     32'(m_opq));
        check({tag, ".op_q2"},     32'(op_q2),     32'(m_opq));
        check({tag, ".cov8"},      32'(cov8),      32'(exp_cov));
        check({tag, ".cov2"},      32'(cov2),      32'(exp_cov));
        check({tag, ".all_seen8"}, 32'(all_seen8), 32'(all));
        check({tag, ".all_seen2"}, 32'(all_seen2), 32'(all));
        check({tag, ".hi_count8"}, 32'(hi_count8), 32'(m_cnt8));
        check({tag, ".hi_count2"}, 32'(hi_count2), 32'(m_cnt2));
    endtask

    // One clock step: drive after the falling edge, check op, let the rising
    // edge sample, update the model and check the registered outputs.
    task automatic step(input string tag, input bit a, input bit b, input bit r);
        @(negedge clk);
        input1 = a;
        input2 = b;
        rst    = r;
        #1;
        check({tag, ".op8"}, 32'(op8), 32'(a & b));
        check({tag, ".op2"}, 32'(op2), 32'(a & b));
        @(posedge clk);
        #1;
        if (r) begin
            m_opq  = 1'b0;
            m_cnt8 = 0;
            m_cnt2 = 0;
            for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
        end else begin
            m_opq  = a & b;
            m_seen[{a, b}] = 1'b1;
            m_cnt8 = sat_add(m_cnt8, int'(a & b), 8);
            m_cnt2 = sat_add(m_cnt2, int'(a & b), 2);
        end
        check_regs(tag);
    endtask

    initial begin
        rst    = 1'b1;
        input1 = 1'b0;
        input2 = 1'b0;

        // Combinational truth table while reset is held
        #1; check("tt00", 32'(op8), 32'd0);
        input1 = 1'b1; input2 = 1'b0; #5; check("tt10", 32'(op8), 32'd0);
        input1 = 1'b0; input2 = 1'b1; #5; check("tt01", 32'(op8), 32'd0);
        input1 = 1'b1; input2 = 1'b1; #5; check("tt11", 32'(op8), 32'd1);
        check("tt11_w2", 32'(op2), 32'd1);

        // Reset state
        step("reset", 1'b1, 1'b1, 1'b1);
        check("reset.cov_const", 32'(cov8), 32'd0);

        // Coverage progression
        step("cov00", 1'b0, 1'b0, 1'b0);
        check("cov00.const", 32'(cov8), 32'h1);
        step("cov10", 1'b1, 1'b0, 1'b0);
        check("cov10.const", 32'(cov8), 32'h5);
        step("cov01", 1'b0, 1'b1, 1'b0);
        check("cov01.const", 32'(cov8), 32'h7);
        check("cov01.all_const", 32'(all_seen8), 32'd0);
        step("cov11", 1'b1, 1'b1, 1'b0);
        check("cov11.const", 32'(cov8), 32'hF);
        check("cov11.all_const", 32'(all_seen8), 32'd1);

        // Build hi_count up to 5, then reset mid-run with inputs 11
        for (int i = 0; i < 4; i++) step("build", 1'b1, 1'b1, 1'b0);
        check("build.hi_const", 32'(hi_count8), 32'd5);
        step("midrst", 1'b1, 1'b1, 1'b1);
        check("midrst.op_const", 32'(op8), 32'd1);
        check("midrst.hi_const", 32'(hi_count8), 32'd0);
        step("postrst", 1'b1, 1'b1, 1'b0);
        check("postrst.cov_const", 32'(cov8), 32'h8);
        check("postrst.hi_const", 32'(hi_count8), 32'd1);

        // Saturation of the 2-bit counter from zero
        step("satrst", 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step("sat", 1'b1, 1'b1, 1'b0);
            check("sat.hi2_const", 32'(hi_count2), (i < 3) ? 32'(i + 1) : 32'd3);
        end

        // Registered copy
        step("reg11", 1'b1, 1'b1, 1'b0);
        check("reg11.const", 32'(op_q8), 32'd1);
        step("reg01", 1'b0, 1'b1, 1'b0);
        check("reg01.const", 32'(op_q8), 32'd0);

        // Mid-cycle input change affects op only
        @(negedge clk);
        input1 = 1'b1; input2 = 1'b1;
        #1;
        check("midcyc.op", 32'(op8), 32'd1);
        check("midcyc.op_q", 32'(op_q8), 32'(m_opq));
        check("midcyc.hi", 32'(hi_count8), 32'(m_cnt8));

        // Random stimulus with occasional reset
        step("rand_init", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(1)), 1'($urandom_range(1)),
                 ($urandom_range(31) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_my_and
